// File: rtl/fft_pkg.sv
// fft_pkg: constants and helpers shared by the 32-point DIT FFT blocks
// (input loader, butterflies, pipeline stages).
//   FFT_POINTS / FFT_LOG2 : transform size and its log2
//   loader_state_e        : input loader state, also exposed on dbg_state
//   bitrev5               : 5-bit index bit reversal (DIT input ordering)
//   slot_off              : bit offset of slot k in a flattened bus of n-bit lanes
package fft_pkg;

    localparam int FFT_POINTS = 32;
    localparam int FFT_LOG2   = 5;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } loader_state_e;

    function automatic logic [FFT_LOG2-1:0] bitrev5(input logic [FFT_LOG2-1:0] idx);
        logic [FFT_LOG2-1:0] rev;
        for (int b = 0; b < FFT_LOG2; b++) begin
            rev[b] = idx[FFT_LOG2-1-b];
        end
        return rev;
    endfunction

    function automatic int slot_off(input int k, input int n);
        return k * n;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: one 32-slot frame buffer of complex samples.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset (clears every slot)
//   we, waddr     : write enable and 5-bit slot address
//   wr_r, wr_i    : real / imaginary component written into slot waddr
//   rd_r, rd_i    : all slots flattened, slot k at [k*N +: N], straight from registers
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [FFT_LOG2-1:0]      waddr,
    input  logic [N-1:0]             wr_r,
    input  logic [N-1:0]             wr_i,
    output logic [FFT_POINTS*N-1:0]  rd_r,
    output logic [FFT_POINTS*N-1:0]  rd_i
);

    logic [N-1:0] slot_r [FFT_POINTS];
    logic [N-1:0] slot_i [FFT_POINTS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < FFT_POINTS; k++) begin
                slot_r[k] <= '0;
                slot_i[k] <= '0;
            end
        end else begin
            for (int k = 0; k < FFT_POINTS; k++) begin
                if (we && (waddr == FFT_LOG2'(k))) begin
                    slot_r[k] <= wr_r;
                    slot_i[k] <= wr_i;
                end
            end
        end
    end

    for (genvar k = 0; k < FFT_POINTS; k++) begin : g_flat
        assign rd_r[slot_off(k, N) +: N] = slot_r[k];
        assign rd_i[slot_off(k, N) +: N] = slot_i[k];
    end

endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: serial-to-parallel front end of the 32-point DIT FFT.
// Samples arrive one per handshake in natural order; sample cnt is stored in
// slot bitrev5(cnt), and the completed frame is offered as flattened buses.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   in_valid/in_ready        : serial sample handshake, with in_r, in_i, in_last
//   frame_valid/frame_ready  : frame handshake, with out_r, out_i (slot k at [k*N +: N])
//   frame_err                : one-cycle pulse when in_last disagrees with the sample count
//   dbg_state                : FILL while a sample can be taken, HOLD while stalled on a full frame
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// valid never depends on ready, and out_r/out_i are held while frame_valid waits.
// Build option FFT_LOADER_PINGPONG_EN: two banks, one filling while the other is
// presented, giving 32 cycles per frame instead of 33.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_r,
    input  logic [N-1:0]             in_i,
    input  logic                     in_last,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [FFT_POINTS*N-1:0]  out_r,
    output logic [FFT_POINTS*N-1:0]  out_i,
    output logic                     frame_err,
    output loader_state_e            dbg_state
);

    logic [FFT_LOG2-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                accept;
    logic                complete;
    logic [FFT_LOG2-1:0] waddr;

    assign accept = in_valid && in_ready;
    assign waddr  = bitrev5(cnt_q);

    // Sample counting and framing checks. A late in_last still completes the
    // frame; an early one drops the partial frame and restarts at slot mapping 0.
    always_comb begin
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        complete = 1'b0;
        if (accept) begin
            if (cnt_q == FFT_LOG2'(FFT_POINTS - 1)) begin
                cnt_d    = '0;
                complete = 1'b1;
                err_d    = !in_last;
            end else if (in_last) begin
                cnt_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign frame_err = err_q;

`ifdef FFT_LOADER_PINGPONG_EN
    // wr_sel is the bank being filled, rd_sel the bank being presented.
    // Banks are consumed in fill order, so the fill bank is only full when
    // both are; a completion and a handoff always touch different banks.
    logic                    wr_sel_q;
    logic                    rd_sel_q;
    logic [1:0]              full_q;
    logic                    handoff;
    logic [FFT_POINTS*N-1:0] bank_r [2];
    logic [FFT_POINTS*N-1:0] bank_i [2];

    assign in_ready    = rst && !full_q[wr_sel_q];
    assign frame_valid = full_q[rd_sel_q];
    assign handoff     = frame_valid && frame_ready;
    assign dbg_state   = full_q[wr_sel_q] ? ST_HOLD : ST_FILL;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            full_q   <= 2'b00;
        end else begin
            if (complete) begin
                full_q[wr_sel_q] <= 1'b1;
                wr_sel_q         <= !wr_sel_q;
            end
            if (handoff) begin
                full_q[rd_sel_q] <= 1'b0;
                rd_sel_q         <= !rd_sel_q;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(.N(N)) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (accept && (wr_sel_q == 1'(b))),
            .waddr (waddr),
            .wr_r  (in_r),
            .wr_i  (in_i),
            .rd_r  (bank_r[b]),
            .rd_i  (bank_i[b])
        );
    end

    assign out_r = rd_sel_q ? bank_r[1] : bank_r[0];
    assign out_i = rd_sel_q ? bank_i[1] : bank_i[0];
`else
    loader_state_e state_q, state_d;

    // in_ready is gated by rst so nothing is taken while reset is held.
    assign in_ready    = rst && (state_q == ST_FILL);
    assign frame_valid = (state_q == ST_HOLD);
    assign dbg_state   = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (complete)    state_d = ST_HOLD;
            ST_HOLD: if (frame_ready) state_d = ST_FILL;
            default:                  state_d = ST_FILL;
        endcase
    end

    // No writes happen in HOLD, so the presented frame is frozen there.
    fft_frame_bank #(.N(N)) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr (waddr),
        .wr_r  (in_r),
        .wr_i  (in_i),
        .rd_r  (out_r),
        .rd_i  (out_i)
    );
`endif

endmodule
